// File: rtl/fetch_queue_stage_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   NopWordDefault : encoding of "ori $zero,$zero,0", shown to decode when nothing is valid
//   PcInc          : byte distance between sequential instruction words
//   fetch_entry_t  : one buffered fetch (instruction word plus its PC) at the 32-bit widths
package fetch_queue_stage_pkg;

    localparam logic [31:0] NopWordDefault = 32'h3400_0000;
    localparam int unsigned PcInc          = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// Circular buffer holding fetched words between the ROM and decode.
// Ports:
//   clk_i / rst_ni : clock, asynchronous active-low reset
//   push_i, wdata_i: write one entry at the tail
//   pop_i          : retire the head entry (ignored when empty)
//   flush_i        : discard every entry; wins over push and pop
//   rdata_o        : head entry (contents undefined when count_o == 0)
//   count_o        : number of entries currently held (0..DEPTH)
module fetch_queue_stage_fifo #(
    parameter int unsigned Width = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Width-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i & ~flush_i;
        do_pop   = pop_i & ~flush_i & (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observed once count_q covers it.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // The issue logic upstream reserves a slot before fetching, so a push can
    // only meet a full buffer when the head is leaving in the same cycle.
    push_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !flush_i && !pop_i && (count_q == CntW'(DEPTH))));

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: owns the PC, reads a synchronous ROM (one cycle
// latency) and queues fetched words with their PC for decode.
// Ports:
//   clk_i / rst_ni        : clock, asynchronous active-low reset
//   redirect_valid_i/pc_i : taken branch/jump; flushes everything and restarts at pc
//   imem_rd_en_o/addr_o   : ROM read strobe and byte address
//   imem_rdata_i          : ROM word, valid the cycle after imem_rd_en_o
//   out_valid_o/ready_i   : handshake towards decode
//   out_instr_o           : head word, NOP_WORD when nothing is valid
//   out_pc_o/plus4_o      : head PC and PC+4; hold the last head when empty
//   occupancy_o           : entries held in the queue
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [DW-1:0] NOP_WORD = DW'(NopWordDefault),
    localparam int unsigned  CntW     = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_valid_i,
    input  logic [AW-1:0]   redirect_pc_i,
    output logic            imem_rd_en_o,
    output logic [AW-1:0]   imem_addr_o,
    input  logic [DW-1:0]   imem_rdata_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [DW-1:0]   out_instr_o,
    output logic [AW-1:0]   out_pc_o,
    output logic [AW-1:0]   out_pc_plus4_o,
    output logic [CntW-1:0] occupancy_o
);

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    localparam int unsigned   EntryW   = DW + AW;
    localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

    logic            started_q;
    logic [AW-1:0]   pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [AW-1:0]   inflight_pc_q, inflight_pc_d;
    logic [AW-1:0]   last_pc_q, last_pc_d;
    logic [AW-1:0]   last_pc4_q, last_pc4_d;

    logic [CntW-1:0] count;
    logic [CntW:0]   demand;
    logic            head_valid, pop, push, issue;
    entry_t          push_entry, head_entry;
    logic [EntryW-1:0] fifo_rdata;

    // Issue control: a fetch only goes out when a slot is guaranteed for its
    // response, counting the word already in flight and any head leaving now.
    always_comb begin
        head_valid = (count != '0);
        pop        = head_valid & out_ready_i & ~redirect_valid_i;
        demand     = {1'b0, count} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
        // started_q keeps the ROM idle during reset and the cycle of its release.
        issue      = started_q & ~redirect_valid_i & (demand < DepthLim);
        // A redirect kills the response arriving in the same cycle.
        push       = inflight_q & ~redirect_valid_i;

        push_entry.instr = imem_rdata_i;
        push_entry.pc    = inflight_pc_q;
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (issue) begin
            pc_d          = pc_q + AW'(PcInc);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            started_q     <= 1'b0;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            last_pc_q     <= '0;
            last_pc4_q    <= '0;
        end else begin
            started_q     <= 1'b1;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            last_pc_q     <= last_pc_d;
            last_pc4_q    <= last_pc4_d;
        end
    end

    fetch_queue_stage_fifo #(
        .Width (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .flush_i (redirect_valid_i),
        .rdata_o (fifo_rdata),
        .count_o (count)
    );

    // Output mux: PC outputs follow the head and freeze on it once the queue empties.
    always_comb begin
        head_entry = entry_t'(fifo_rdata);
        last_pc_d  = last_pc_q;
        last_pc4_d = last_pc4_q;
        if (head_valid) begin
            last_pc_d  = head_entry.pc;
            last_pc4_d = head_entry.pc + AW'(PcInc);
        end

        imem_rd_en_o   = issue;
        imem_addr_o    = pc_q;
        out_valid_o    = head_valid;
        out_instr_o    = head_valid ? head_entry.instr : NOP_WORD;
        out_pc_o       = last_pc_d;
        out_pc_plus4_o = last_pc4_d;
        occupancy_o    = count;
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: a scoreboard of expected PCs is filled
// when stimulus is applied and drained on every decode handshake. A second
// instance with RESET_PC near the top of the address space covers PC wrap.
module tb_fetch_queue_stage;

    localparam logic [31:0] Nop  = 32'h3400_0000;
    localparam logic [31:0] WKey = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;

    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_instr, out_pc, out_pc_plus4;
    logic [2:0]  occupancy;

    logic        w_rd_en;
    logic [31:0] w_addr;
    logic [31:0] w_rdata = '0;
    logic        w_valid;
    logic [31:0] w_instr, w_pc, w_pc4;
    logic [2:0]  w_occ;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];
    logic [31:0] wexp[4];

    always #5 clk = ~clk;

    // Synchronous ROMs: word = address (main), address ^ WKey (wrap instance).
    always @(posedge clk) if (imem_rd_en) imem_rdata <= imem_addr;
    always @(posedge clk) if (w_rd_en) w_rdata <= w_addr ^ WKey;

    fetch_queue_stage dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_rd_en_o     (imem_rd_en),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_instr_o      (out_instr),
        .out_pc_o         (out_pc),
        .out_pc_plus4_o   (out_pc_plus4),
        .occupancy_o      (occupancy)
    );

    fetch_queue_stage #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_w (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .redirect_valid_i (1'b0),
        .redirect_pc_i    (32'h0),
        .imem_rd_en_o     (w_rd_en),
        .imem_addr_o      (w_addr),
        .imem_rdata_i     (w_rdata),
        .out_valid_o      (w_valid),
        .out_ready_i      (1'b1),
        .out_instr_o      (w_instr),
        .out_pc_o         (w_pc),
        .out_pc_plus4_o   (w_pc4),
        .occupancy_o      (w_occ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs set for the coming edge; scores a handshake.
    task automatic cyc();
        logic [31:0] e;
        if (out_valid === 1'b1 && out_ready && !redirect_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed_pc=%h expected=none", out_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_pc", out_pc, e);
                check("sb_instr", out_instr, e);
                check("sb_pc_plus4", out_pc_plus4, e + 32'd4);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) cyc();
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_instr", out_instr, Nop);
        check("rst_pc", out_pc, 32'd0);
        check("rst_pc4", out_pc_plus4, 32'd0);
        check("rst_rd_en", 32'(imem_rd_en), 32'd0);
        check("rst_w_occ", 32'(w_occ), 32'd0);

        // 1. Streaming with decode always ready
        rst_n = 1'b1;
        out_ready = 1'b1;
        push_seq(32'h0, 8);
        cyc();
        check("t1_c1_rd_en", 32'(imem_rd_en), 32'd1);
        check("t1_c1_addr", imem_addr, 32'h0);
        check("t1_c1_valid", 32'(out_valid), 32'd0);
        cyc();
        check("t1_c2_valid", 32'(out_valid), 32'd0);
        check("t1_c2_addr", imem_addr, 32'h4);
        cyc();
        check("t1_c3_instr", out_instr, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("t1_steady_valid", 32'(out_valid), 32'd1);
            cyc();
        end
        drain("t1_drain");

        // 2. Decode stalls for 10 cycles, then resumes without gaps
        out_ready = 1'b0;
        repeat (10) cyc();
        check("t2_occ_full", 32'(occupancy), 32'd4);
        check("t2_rd_en_off", 32'(imem_rd_en), 32'd0);
        push_seq(32'h20, 5);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_nogap_valid", 32'(out_valid), 32'd1);
            cyc();
        end
        check("t2_drain", 32'(sb.size()), 32'd0);

        // 3. Redirect while three entries are queued; head is 0x34
        out_ready = 1'b0;
        for (int i = 0; i < 20 && occupancy != 3'd3; i++) cyc();
        check("t3_occ3", 32'(occupancy), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        sb.delete();
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("t3_occ0", 32'(occupancy), 32'd0);
        check("t3_valid", 32'(out_valid), 32'd0);
        check("t3_nop", out_instr, Nop);
        check("t3_hold_pc", out_pc, 32'h34);
        check("t3_hold_pc4", out_pc_plus4, 32'h38);
        check("t3_issue_addr", imem_addr, 32'h100);
        check("t3_issue_en", 32'(imem_rd_en), 32'd1);
        push_seq(32'h100, 3);
        out_ready = 1'b1;
        drain("t3_drain");

        // 4. Redirect in the cycle after an issue: its response must be dropped
        out_ready = 1'b0;
        #1;
        check("t4_issue", 32'(imem_rd_en), 32'd1);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        sb.delete();
        push_seq(32'h200, 3);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("t4_occ0", 32'(occupancy), 32'd0);
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_addr", imem_addr, 32'h200);
        out_ready = 1'b1;
        drain("t4_drain");

        // 6. Reset mid-stream with two entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 20 && occupancy != 3'd2; i++) cyc();
        check("t6_occ2", 32'(occupancy), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_occ", 32'(occupancy), 32'd0);
        check("t6_instr", out_instr, Nop);
        check("t6_pc", out_pc, 32'd0);
        check("t6_pc4", out_pc_plus4, 32'd0);
        check("t6_rd_en", 32'(imem_rd_en), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        sb.delete();
        push_seq(32'h0, 4);
        out_ready = 1'b1;
        cyc();
        check("t6_restart_addr", imem_addr, 32'h0);
        check("t6_restart_en", 32'(imem_rd_en), 32'd1);
        check("t5_first_addr", w_addr, 32'hFFFF_FFF8);
        cyc();
        cyc();

        // 5. PC wrap on the RESET_PC=0xFFFFFFF8 instance, alongside the restart
        for (int i = 0; i < 4; i++) begin
            check("t5_valid", 32'(w_valid), 32'd1);
            check("t5_pc", w_pc, wexp[i]);
            check("t5_instr", w_instr, wexp[i] ^ WKey);
            check("t5_pc4", w_pc4, wexp[i] + 32'd4);
            cyc();
        end
        check("t6_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
